// File: rtl/greenhouse_pkg.sv
// Shared types and constants for the greenhouse climate controller.
package greenhouse_pkg;

  localparam int TEMP_W       = 8;
  localparam int TEMP_XW      = 9;
  localparam int HYST_DEFAULT = 2;

  localparam logic signed [TEMP_XW-1:0] TEMP_MIN_X = -9'sd40;
  localparam logic signed [TEMP_XW-1:0] TEMP_MAX_X = 9'sd85;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HEAT_SOLAR = 3'd1,
    ST_HEAT_GEO   = 3'd2,
    ST_COOL_VENT  = 3'd3,
    ST_COOL_GEO   = 3'd4
  } state_e;

  function automatic logic signed [TEMP_XW-1:0] sext(input logic signed [TEMP_W-1:0] t);
    return {t[TEMP_W-1], t};
  endfunction

  function automatic logic in_range(input logic signed [TEMP_W-1:0] t);
    return (sext(t) >= TEMP_MIN_X) && (sext(t) <= TEMP_MAX_X);
  endfunction

endpackage

// File: rtl/greenhouse_climate_fsm_dwell_timer.sv
// Minimum-dwell down-counter: reloads on a state change, saturates at zero.
module greenhouse_climate_fsm_dwell_timer #(
  parameter int DWELL_W          = 32,
  parameter int MIN_DWELL_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic done_o
);

  localparam logic [DWELL_W-1:0] LOAD_V = DWELL_W'(MIN_DWELL_CYCLES - 1);

  logic [DWELL_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_V;
    end else if (count_q != '0) begin
      count_d = count_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/greenhouse_climate_fsm.sv
// Greenhouse heat/cool source selection with hysteresis and minimum dwell.
// Optional sensor range fault: define SENSOR_RANGE_CHECK_EN.
//
// state       | meaning
// IDLE        | no source active
// HEAT_SOLAR  | solar loop pump heating
// HEAT_GEO    | geothermal pump heating
// COOL_VENT   | ambient vent cooling
// COOL_GEO    | geothermal pump cooling
module greenhouse_climate_fsm
  import greenhouse_pkg::*;
#(
  parameter int MIN_DWELL_CYCLES = 1000,
  parameter int HYST             = HYST_DEFAULT,
  parameter int DWELL_W          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [15:0]              solar_light,
  input  logic signed [TEMP_W-1:0] solar_temp,
  input  logic signed [TEMP_W-1:0] greenhouse_temp,
  input  logic signed [TEMP_W-1:0] ambient_temp,
  input  logic signed [TEMP_W-1:0] geothermal_temp,
  input  logic [15:0]              solar_th,
  input  logic signed [TEMP_W-1:0] solar_cooldown_th,
  input  logic signed [TEMP_W-1:0] solar_heatup_th,
  input  logic signed [TEMP_W-1:0] greenhouse_cooldown_th,
  input  logic signed [TEMP_W-1:0] greenhouse_heatup_th,
  input  logic signed [TEMP_W-1:0] ambient_cooldown_th,
  input  logic signed [TEMP_W-1:0] ambient_heatup_th,
  input  logic signed [TEMP_W-1:0] geothermal_cooldown_th,
  input  logic signed [TEMP_W-1:0] geothermal_heatup_th,
  output logic                     pump_solar_en,
  output logic                     pump_geo_en,
  output logic                     vent_open,
  output logic                     solar_dump,
`ifdef SENSOR_RANGE_CHECK_EN
  output logic                     sensor_fault,
`endif
  output logic [2:0]               state_o
);

  localparam logic signed [TEMP_XW-1:0] HYST_X = TEMP_XW'(HYST);

  state_e state_q, state_d, sel;
  logic   dwell_done, eval, force_idle;
  logic   solar_ok, geo_heat_ok, vent_ok, geo_cool_ok;
  logic   need_cool, need_heat, heat_exit, cool_exit;
  logic   dump_q, dump_d;
  logic signed [TEMP_XW-1:0] gh_x, gh_cool_x, gh_heat_x;

  // ambient_heatup_th has no consumer in the selection rules.
  logic unused_amb_heat;
  assign unused_amb_heat = ^ambient_heatup_th;

  assign gh_x      = sext(greenhouse_temp);
  assign gh_cool_x = sext(greenhouse_cooldown_th);
  assign gh_heat_x = sext(greenhouse_heatup_th);

  assign need_cool = gh_x > gh_cool_x;
  assign need_heat = gh_x < gh_heat_x;
  assign heat_exit = gh_x >= (gh_heat_x + HYST_X);
  assign cool_exit = gh_x <= (gh_cool_x - HYST_X);

  assign solar_ok    = (solar_light >= solar_th) && (sext(solar_temp) > sext(solar_heatup_th));
  assign geo_heat_ok = sext(geothermal_temp) > sext(geothermal_heatup_th);
  assign vent_ok     = sext(ambient_temp) < sext(ambient_cooldown_th);
  assign geo_cool_ok = sext(geothermal_temp) < sext(geothermal_cooldown_th);

  assign eval = sample_valid && dwell_done;

`ifdef SENSOR_RANGE_CHECK_EN
  logic fault_q, range_bad;
  assign range_bad = sample_valid && !(in_range(solar_temp) && in_range(greenhouse_temp) &&
                                       in_range(ambient_temp) && in_range(geothermal_temp));
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_q | range_bad;
    end
  end
  assign sensor_fault = fault_q;
  assign force_idle   = fault_q | range_bad;
`else
  assign force_idle = 1'b0;
`endif

  always_comb begin
    sel = ST_IDLE;
    if (need_cool) begin
      if (vent_ok)          sel = ST_COOL_VENT;
      else if (geo_cool_ok) sel = ST_COOL_GEO;
    end else if (need_heat) begin
      if (solar_ok)         sel = ST_HEAT_SOLAR;
      else if (geo_heat_ok) sel = ST_HEAT_GEO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dump_q  <= dump_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dump_d  = sample_valid ? (sext(solar_temp) >= sext(solar_cooldown_th)) : dump_q;
    case (state_q)
      ST_IDLE: begin
        if (eval) state_d = sel;
      end
      ST_HEAT_SOLAR: begin
        if (eval) begin
          if (heat_exit)     state_d = ST_IDLE;
          else if (!solar_ok) state_d = sel;
        end
      end
      ST_HEAT_GEO: begin
        if (eval) begin
          if (heat_exit)        state_d = ST_IDLE;
          else if (!geo_heat_ok) state_d = sel;
        end
      end
      ST_COOL_VENT: begin
        if (eval) begin
          if (cool_exit)    state_d = ST_IDLE;
          else if (!vent_ok) state_d = sel;
        end
      end
      ST_COOL_GEO: begin
        if (eval) begin
          if (cool_exit)        state_d = ST_IDLE;
          else if (!geo_cool_ok) state_d = sel;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (force_idle) state_d = ST_IDLE;
  end

  // Any change of state, including recovery from an illegal code, restarts the dwell.
  greenhouse_climate_fsm_dwell_timer #(
    .DWELL_W         (DWELL_W),
    .MIN_DWELL_CYCLES(MIN_DWELL_CYCLES)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load_i(state_d != state_q),
    .done_o(dwell_done)
  );

  always_comb begin
    pump_solar_en = 1'b0;
    pump_geo_en   = 1'b0;
    vent_open     = 1'b0;
    case (state_q)
      ST_HEAT_SOLAR: pump_solar_en = 1'b1;
      ST_HEAT_GEO:   pump_geo_en   = 1'b1;
      ST_COOL_GEO:   pump_geo_en   = 1'b1;
      ST_COOL_VENT:  vent_open     = 1'b1;
      default: ;
    endcase
  end

  assign state_o    = state_q;
  assign solar_dump = dump_q;

endmodule
